// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, load/store and memory-side signals of the shared memory port.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_done;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic [DW-1:0]   d_rdata;
    logic            d_done;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;
    logic            timeout_err;

    // Arbiter side: serves both requesters and drives the memory.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               mem_wstrb, timeout_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_ack,
        input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               mem_wstrb, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Data-first arbiter for the single memory port with fetch
//            anti-starvation streak limit and per-transaction ack timeout.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);
    localparam int c_sw = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_sw-1:0] c_streak_max = c_sw'(MAX_D_STREAK);
    localparam logic [c_tw-1:0] c_tmo_last   = c_tw'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_if_busy = 2'd1;
    localparam logic [1:0] c_st_d_busy  = 2'd2;
    localparam logic [1:0] c_st_resp    = 2'd3;

    logic [1:0]      r_state;
    logic [c_sw-1:0] r_streak;
    logic [c_tw-1:0] r_tmo;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW/8-1:0] r_mem_wstrb;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_if_done;
    logic            r_d_done;
    logic            r_timeout_err;

    logic w_d_blocked;
    logic w_grant_d;
    logic w_finish;

    // Data loses its priority only once it has starved a waiting fetch long enough.
    assign w_d_blocked = bus.if_req && (MAX_D_STREAK != 0) && (r_streak == c_streak_max);
    assign w_grant_d   = bus.d_req && !w_d_blocked;
    assign w_finish    = bus.mem_ack || (r_tmo == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_streak      <= '0;
            r_tmo         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_if_done     <= 1'b0;
            r_d_done      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_tmo <= '0;
                    if (w_grant_d) begin
                        r_state     <= c_st_d_busy;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_wstrb <= bus.d_we ? bus.d_wstrb : '0;
                        if (!bus.if_req) begin
                            r_streak <= '0;
                        end else if (r_streak != c_streak_max) begin
                            r_streak <= r_streak + c_sw'(1);
                        end
                    end else if (bus.if_req) begin
                        r_state     <= c_st_if_busy;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                        r_mem_wstrb <= '0;
                        r_streak    <= '0;
                    end
                end
                c_st_if_busy, c_st_d_busy: begin
                    if (w_finish) begin
                        // An aborted transfer returns zero data and latches the error flag.
                        r_mem_req <= 1'b0;
                        r_state   <= c_st_resp;
                        if (r_state == c_st_if_busy) begin
                            r_if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                            r_if_done  <= 1'b1;
                        end else begin
                            r_d_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                            r_d_done  <= 1'b1;
                        end
                        if (!bus.mem_ack) begin
                            r_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + c_tw'(1);
                    end
                end
                c_st_resp: begin
                    r_state   <= c_st_idle;
                    r_if_done <= 1'b0;
                    r_d_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wstrb   = r_mem_wstrb;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.if_done     = r_if_done;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.d_done      = r_d_done;
    assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus0 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(0), .TIMEOUT(TMO)) dut_strict (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder for the main DUT: ack a fixed number of cycles after mem_req rises.
    int   ack_dly   = 0;
    int   busy_cnt  = 0;
    logic rd_inc    = 1'b0;
    logic [31:0] rd_val = 32'h0;
    logic resp_ack  = 1'b0;
    logic force_ack = 1'b0;
    assign bus0.mem_ack = resp_ack | force_ack;

    always begin
        @(posedge clk);
        #2;
        if (bus0.mem_req) begin
            resp_ack = (ack_dly >= 0) && (busy_cnt == ack_dly);
            if (resp_ack) begin
                bus0.mem_rdata = rd_val;
                if (rd_inc) rd_val = rd_val + 32'd1;
            end
            busy_cnt++;
        end else begin
            resp_ack = 1'b0;
            busy_cnt = 0;
        end
    end

    always begin
        @(posedge clk);
        #2;
        bus1.mem_ack   = bus1.mem_req && !bus1.mem_ack;
        bus1.mem_rdata = 32'h1;
    end

    // Reference model: whole-transaction view built from the arbitration rules.
    int   m_owner  = 0;  // 0 none, 1 fetch, 2 data
    int   m_wait   = 0;
    int   m_streak = 0;
    bit   m_resp   = 0;
    bit   m_lim;
    logic        e_mem_req = 0, e_mem_we = 0, e_if_done = 0, e_d_done = 0, e_tmo = 0;
    logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;
    logic [3:0]  e_mem_wstrb = 0;
    byte         mlog[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_wait = 0; m_streak = 0; m_resp = 0;
            e_mem_req = 0; e_mem_we = 0; e_if_done = 0; e_d_done = 0; e_tmo = 0;
            e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0; e_mem_wstrb = 0;
        end else if (m_resp) begin
            m_resp = 0; e_if_done = 0; e_d_done = 0;
        end else if (m_owner == 0) begin
            m_lim = bus0.if_req && (MAXS != 0) && (m_streak == MAXS);
            if (bus0.d_req && !m_lim) begin
                m_owner = 2; m_wait = 0; e_mem_req = 1;
                e_mem_we = bus0.d_we; e_mem_addr = bus0.d_addr; e_mem_wdata = bus0.d_wdata;
                e_mem_wstrb = bus0.d_we ? bus0.d_wstrb : 4'h0;
                m_streak = bus0.if_req ? ((m_streak < MAXS) ? m_streak + 1 : m_streak) : 0;
                mlog.push_back(8'h44);
            end else if (bus0.if_req) begin
                m_owner = 1; m_wait = 0; e_mem_req = 1;
                e_mem_we = 0; e_mem_addr = bus0.if_addr; e_mem_wstrb = 4'h0;
                m_streak = 0;
                mlog.push_back(8'h49);
            end
        end else begin
            if (bus0.mem_ack || (m_wait + 1 >= TMO)) begin
                if (m_owner == 1) e_if_rdata = bus0.mem_ack ? bus0.mem_rdata : 32'h0;
                else              e_d_rdata  = bus0.mem_ack ? bus0.mem_rdata : 32'h0;
                if (!bus0.mem_ack) e_tmo = 1;
                e_if_done = (m_owner == 1);
                e_d_done  = (m_owner == 2);
                e_mem_req = 0; m_owner = 0; m_resp = 1;
            end else begin
                m_wait++;
            end
        end
    end

    // Per-cycle comparison and event bookkeeping, half a cycle after the active edge.
    int   n_if = 0, n_d = 0, n_if1 = 0, n_d1 = 0;
    int   last_if_cyc = 0, prev_if_cyc = 0, last_d_cyc = 0;
    int   run = 0, last_run = 0;
    logic prev_req = 0;
    logic [31:0] g_addr = 0, g_wdata = 0;
    logic        g_we = 0;
    logic [3:0]  g_wstrb = 0;
    byte         dut_glog[$];

    always @(negedge clk) begin
        chk("mem_req", bus0.mem_req, e_mem_req);
        if (e_mem_req) begin
            chk("mem_addr", bus0.mem_addr, e_mem_addr);
            chk("mem_we", bus0.mem_we, e_mem_we);
            chk("mem_wstrb", bus0.mem_wstrb, e_mem_wstrb);
            if (e_mem_we) chk("mem_wdata", bus0.mem_wdata, e_mem_wdata);
        end
        chk("if_done", bus0.if_done, e_if_done);
        chk("d_done", bus0.d_done, e_d_done);
        chk("if_rdata", bus0.if_rdata, e_if_rdata);
        chk("d_rdata", bus0.d_rdata, e_d_rdata);
        chk("timeout_err", bus0.timeout_err, e_tmo);

        if (bus0.if_done) begin n_if++; prev_if_cyc = last_if_cyc; last_if_cyc = cyc; end
        if (bus0.d_done)  begin n_d++;  last_d_cyc = cyc; end
        if (bus1.if_done) n_if1++;
        if (bus1.d_done)  n_d1++;
        if (bus0.mem_req) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        if (bus0.mem_req && !prev_req) begin
            g_addr = bus0.mem_addr; g_we = bus0.mem_we;
            g_wstrb = bus0.mem_wstrb; g_wdata = bus0.mem_wdata;
            dut_glog.push_back((bus0.mem_addr == bus0.if_addr) ? 8'h49 : 8'h44);
        end
        prev_req = bus0.mem_req;
    end

    task automatic wait_cnt(input bit is_d, input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (((is_d ? n_d : n_if) < target) && (k < budget)) begin
            step(1);
            k++;
        end
        chk(nm, 64'(k < budget), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1);
    end

    int    c0, base;
    string exp_order;

    initial begin
        bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_addr = 0; bus0.d_wdata = 0; bus0.d_wstrb = 0; bus0.mem_rdata = 0;
        bus1.if_req = 0; bus1.if_addr = 32'h40; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 32'h80; bus1.d_wdata = 0; bus1.d_wstrb = 0;
        bus1.mem_ack = 0; bus1.mem_rdata = 0;
        exp_order = "DDDDIDDDDI";

        step(3);
        chk("rst_mem_req", bus0.mem_req, 0);
        chk("rst_if_rdata", bus0.if_rdata, 0);
        chk("rst_timeout_err", bus0.timeout_err, 0);
        rst = 0;
        step(2);

        // Fetch only, ack two cycles after mem_req.
        ack_dly = 2; rd_val = 32'h00500093;
        bus0.if_addr = 32'h100; bus0.if_req = 1; c0 = cyc;
        wait_cnt(0, 1, 20, "t1_wait");
        bus0.if_req = 0;
        chk("t1_latency", last_if_cyc - c0, 4);
        chk("t1_if_rdata", bus0.if_rdata, 32'h00500093);
        chk("t1_model_rdata", e_if_rdata, 32'h00500093);
        chk("t1_addr", g_addr, 32'h100);
        chk("t1_we", g_we, 0);
        step(3);
        chk("t1_if_pulses", n_if, 1);
        chk("t1_d_pulses", n_d, 0);

        // Store with immediate ack.
        ack_dly = 0; rd_val = 32'h12345678;
        bus0.d_we = 1; bus0.d_addr = 32'h2000; bus0.d_wdata = 32'hCAFEF00D;
        bus0.d_wstrb = 4'hF; bus0.d_req = 1; c0 = cyc;
        wait_cnt(1, 1, 20, "t2_wait");
        bus0.d_req = 0;
        chk("t2_latency", last_d_cyc - c0, 2);
        chk("t2_back_idle", cyc - c0, 3);
        chk("t2_we", g_we, 1);
        chk("t2_wstrb", g_wstrb, 4'hF);
        chk("t2_wdata", g_wdata, 32'hCAFEF00D);
        step(2);

        // Contention: both requesters held; strict-priority instance alongside.
        ack_dly = 1; rd_val = 32'h11110000; rd_inc = 1;
        bus0.d_we = 0; bus0.d_wstrb = 0; bus0.d_addr = 32'h800; bus0.if_addr = 32'h400;
        dut_glog.delete(); mlog.delete();
        bus0.d_req = 1; bus0.if_req = 1; bus1.d_req = 1; bus1.if_req = 1;
        begin
            int k;
            k = 0;
            while ((dut_glog.size() < 10) && (k < 80)) begin step(1); k++; end
            chk("t3_wait", 64'(k < 80), 1);
        end
        bus0.d_req = 0; bus0.if_req = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_order_dut[%0d]", i),
                (i < dut_glog.size()) ? 64'(dut_glog[i]) : 64'd0, 64'(exp_order[i]));
            chk($sformatf("t3_order_model[%0d]", i),
                (i < mlog.size()) ? 64'(mlog[i]) : 64'd0, 64'(exp_order[i]));
        end
        chk("t3_strict_if_never", n_if1, 0);
        chk("t3_strict_d_served", 64'(n_d1 >= 5), 1);
        bus1.d_req = 0;
        begin
            int k;
            k = 0;
            while ((n_if1 < 1) && (k < 12)) begin step(1); k++; end
            chk("t3_strict_if_alone", n_if1, 1);
        end
        bus1.if_req = 0;
        rd_inc = 0;
        step(6);

        // Timeout on a load that never gets acked.
        ack_dly = -1;
        bus0.d_we = 0; bus0.d_addr = 32'h3000; bus0.d_req = 1;
        base = n_d; c0 = cyc;
        wait_cnt(1, base + 1, 30, "t4_wait");
        bus0.d_req = 0;
        chk("t4_latency", last_d_cyc - c0, 9);
        chk("t4_req_cycles", last_run, 8);
        chk("t4_d_rdata", bus0.d_rdata, 0);
        chk("t4_timeout_err", bus0.timeout_err, 1);
        chk("t4_model_err", e_tmo, 1);
        step(1);
        force_ack = 1;
        step(1);
        force_ack = 0;
        step(3);
        chk("t4_err_sticky", bus0.timeout_err, 1);
        chk("t4_late_ack_ignored", n_d, base + 1);

        // Reset in the middle of a fetch.
        bus0.if_addr = 32'h500; bus0.if_req = 1; base = n_if;
        step(3);
        bus0.if_req = 0;
        rst = 1;
        #1;
        chk("t5_mem_req", bus0.mem_req, 0);
        chk("t5_if_done", bus0.if_done, 0);
        chk("t5_timeout_err", bus0.timeout_err, 0);
        chk("t5_d_rdata", bus0.d_rdata, 0);
        step(2);
        rst = 0;
        step(1);
        chk("t5_no_done", n_if, base);
        ack_dly = 1; rd_val = 32'h0BADF00D;
        bus0.if_addr = 32'h504; bus0.if_req = 1; c0 = cyc;
        wait_cnt(0, base + 1, 20, "t5_wait");
        bus0.if_req = 0;
        chk("t5_latency", last_if_cyc - c0, 3);
        chk("t5_if_rdata", bus0.if_rdata, 32'h0BADF00D);
        chk("t5_addr", g_addr, 32'h504);
        step(2);

        // Requester slow to drop: second fetch immediately after RESP.
        ack_dly = 0; rd_val = 32'h0000600D;
        bus0.if_addr = 32'h600; bus0.if_req = 1; base = n_if; c0 = cyc;
        wait_cnt(0, base + 2, 30, "t6_wait");
        bus0.if_req = 0;
        chk("t6_first", prev_if_cyc - c0, 2);
        chk("t6_gap", last_if_cyc - prev_if_cyc, 3);
        chk("t6_addr", g_addr, 32'h600);
        step(4);
        chk("t6_pulses", n_if - base, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
